// File: rtl/m72_pic.sv
// m72_pic: single-device 8259-style interrupt controller for the M72 core.
// Edge-captures eight request lines, resolves fully-nested priority and supplies the ack vector.
module m72_pic #(
   parameter logic [7:0] RESET_MASK = 8'hFF,
   parameter logic [4:0] RESET_BASE = 5'h00
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cs,
   input  logic       stb,
   input  logic       we,
   input  logic       a0,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic [7:0] ir,
   input  logic       int_ack,
   output logic       int_rq,
   output logic [7:0] vector
);

   localparam logic [1:0] ST_READY  = 2'd0;
   localparam logic [1:0] ST_W_ICW2 = 2'd1;
   localparam logic [1:0] ST_W_ICW3 = 2'd2;
   localparam logic [1:0] ST_W_ICW4 = 2'd3;

   logic [1:0] state_q, state_d;
   logic [7:0] irr_q, irr_d;
   logic [7:0] isr_q, isr_d;
   logic [7:0] imr_q, imr_d;
   logic [4:0] base_q, base_d;
   logic       aeoi_q, aeoi_d;
   logic       rd_sel_q, rd_sel_d;
   logic       sngl_q, sngl_d;
   logic       ic4_q, ic4_d;
   logic [7:0] ir_dly_q, ir_dly_d;
   logic       stb_dly_q, stb_dly_d;
   logic       ack_dly_q, ack_dly_d;
   logic [7:0] vector_q, vector_d;
   logic       int_rq_q, int_rq_d;

   logic [7:0] req, req_oh, isr_oh, spec_oh, ack_clr, ir_rise;
   logic [3:0] req_idx, isr_idx;
   logic       has_req, wr_fire, ack_fire, icw1;

   // Index of the lowest set bit; 8 when the vector is empty.
   function automatic logic [3:0] lowest_idx(input logic [7:0] v);
      logic [3:0] idx;
      idx = 4'd8;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   // Bus handshake: an access is a run of stb cycles; a register write (cs & we & ~int_ack)
   // or an acknowledge (int_ack) takes effect only on the first stb cycle of the run.
   always_comb begin
      req      = irr_q & ~imr_q;
      req_oh   = req & (~req + 8'd1);
      isr_oh   = isr_q & (~isr_q + 8'd1);
      spec_oh  = 8'b1 << din[2:0];
      req_idx  = lowest_idx(req);
      isr_idx  = lowest_idx(isr_q);
      has_req  = (req != 8'd0) && (req_idx < isr_idx);
      wr_fire  = cs & stb & we & ~int_ack & ~stb_dly_q;
      ack_fire = int_ack & stb & ~ack_dly_q;
      icw1     = wr_fire & ~a0 & din[4];
      ir_rise  = ir & ~ir_dly_q;

      state_d   = state_q;
      isr_d     = isr_q;
      imr_d     = imr_q;
      base_d    = base_q;
      aeoi_d    = aeoi_q;
      rd_sel_d  = rd_sel_q;
      sngl_d    = sngl_q;
      ic4_d     = ic4_q;
      vector_d  = vector_q;
      ack_clr   = 8'd0;
      ir_dly_d  = ir;
      stb_dly_d = stb;
      ack_dly_d = int_ack & stb;
      int_rq_d  = (state_q == ST_READY) && has_req;

      if (ack_fire) begin
         if (has_req) begin
            vector_d = {base_q, req_idx[2:0]};
            ack_clr  = req_oh;
            if (!aeoi_q) isr_d = isr_q | req_oh;
         end else begin
            vector_d = {base_q, 3'd7};
         end
      end

      if (icw1) begin
         isr_d    = 8'd0;
         imr_d    = RESET_MASK;
         aeoi_d   = 1'b0;
         rd_sel_d = 1'b0;
         sngl_d   = din[1];
         ic4_d    = din[0];
         state_d  = ST_W_ICW2;
      end else if (wr_fire) begin
         case (state_q)
            ST_W_ICW2: if (a0) begin
               base_d  = din[7:3];
               state_d = !sngl_q ? ST_W_ICW3 : (ic4_q ? ST_W_ICW4 : ST_READY);
            end
            ST_W_ICW3: if (a0) begin
               state_d = ic4_q ? ST_W_ICW4 : ST_READY;
            end
            ST_W_ICW4: if (a0) begin
               aeoi_d  = din[1];
               state_d = ST_READY;
            end
            default: begin
               if (a0) begin
                  imr_d = din;
               end else if (din[4:3] == 2'b00) begin
                  if (din[7:5] == 3'b001) isr_d = isr_q & ~isr_oh;
                  else if (din[7:5] == 3'b011) isr_d = isr_q & ~spec_oh;
               end else if (din[4:3] == 2'b01) begin
                  if (din[1]) rd_sel_d = din[0];
               end
            end
         endcase
      end

      // A rising edge in the same cycle as its own acknowledge re-arms the bit.
      irr_d = icw1 ? 8'd0 : ((irr_q & ~ack_clr) | ir_rise);
   end

   always_comb begin
      if (int_ack) dout = vector_q;
      else if (a0) dout = imr_q;
      else dout = rd_sel_q ? isr_q : irr_q;
   end

   assign int_rq = int_rq_q;
   assign vector = vector_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= ST_READY;
         irr_q     <= 8'd0;
         isr_q     <= 8'd0;
         imr_q     <= RESET_MASK;
         base_q    <= RESET_BASE;
         aeoi_q    <= 1'b0;
         rd_sel_q  <= 1'b0;
         sngl_q    <= 1'b0;
         ic4_q     <= 1'b0;
         ir_dly_q  <= 8'd0;
         stb_dly_q <= 1'b0;
         ack_dly_q <= 1'b0;
         vector_q  <= 8'd0;
         int_rq_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         irr_q     <= irr_d;
         isr_q     <= isr_d;
         imr_q     <= imr_d;
         base_q    <= base_d;
         aeoi_q    <= aeoi_d;
         rd_sel_q  <= rd_sel_d;
         sngl_q    <= sngl_d;
         ic4_q     <= ic4_d;
         ir_dly_q  <= ir_dly_d;
         stb_dly_q <= stb_dly_d;
         ack_dly_q <= ack_dly_d;
         vector_q  <= vector_d;
         int_rq_q  <= int_rq_d;
      end
   end

endmodule

// File: tb/tb_m72_pic.sv
// Bench for m72_pic: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a behavioural model.
module tb_m72_pic;

   logic       clock, reset_n, cs, stb, we, a0, int_ack, int_rq;
   logic [7:0] din, dout, ir, vector;

   int errors = 0;
   int checks = 0;
   bit rand_chk = 0;

   m72_pic dut (
      .clock(clock), .reset_n(reset_n), .cs(cs), .stb(stb), .we(we), .a0(a0),
      .din(din), .dout(dout), .ir(ir), .int_ack(int_ack), .int_rq(int_rq),
      .vector(vector)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural reference model ----------------
   logic [7:0] m_irr, m_isr, m_imr, m_vec, m_prev_ir;
   logic [4:0] m_base;
   logic       m_aeoi, m_rdsel, m_sngl, m_ic4, m_prev_stb, m_prev_ack, m_rq;
   int         m_phase;   // 0 = ready, otherwise the ICW number awaited

   function automatic int first_set(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 8;
   endfunction

   function automatic logic [7:0] m_read(input logic sel_a0);
      if (sel_a0) return m_imr;
      return m_rdsel ? m_isr : m_irr;
   endfunction

   task automatic model_clock();
      int r, s;
      bit qual, wr, ack, icw1;
      logic [7:0] rise, clr;
      r = first_set(m_irr & ~m_imr);
      s = first_set(m_isr);
      qual = (r < 8) && (r < s);
      if (!reset_n) begin
         m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_base = 0; m_aeoi = 0; m_rdsel = 0;
         m_sngl = 0; m_ic4 = 0; m_phase = 0; m_prev_ir = 0; m_prev_stb = 0;
         m_prev_ack = 0; m_vec = 0; m_rq = 0;
      end else begin
         rise = ir & ~m_prev_ir;
         clr  = 0;
         icw1 = 0;
         wr   = cs && stb && we && !int_ack && !m_prev_stb;
         ack  = int_ack && stb && !m_prev_ack;
         m_rq = (m_phase == 0) && qual;
         if (ack) begin
            if (qual) begin
               m_vec = {m_base, 3'(r)};
               clr[r] = 1'b1;
               if (!m_aeoi) m_isr[r] = 1'b1;
            end else begin
               m_vec = {m_base, 3'b111};
            end
         end
         if (wr) begin
            if (!a0 && din[4]) begin
               icw1 = 1; m_isr = 0; m_aeoi = 0; m_imr = 8'hFF; m_rdsel = 0;
               m_sngl = din[1]; m_ic4 = din[0]; m_phase = 2;
            end else if (m_phase == 2 && a0) begin
               m_base = din[7:3];
               m_phase = !m_sngl ? 3 : (m_ic4 ? 4 : 0);
            end else if (m_phase == 3 && a0) begin
               m_phase = m_ic4 ? 4 : 0;
            end else if (m_phase == 4 && a0) begin
               m_aeoi = din[1]; m_phase = 0;
            end else if (m_phase == 0) begin
               if (a0) m_imr = din;
               else if (din[4:3] == 2'b00) begin
                  if (din[7:5] == 3'd1 && s < 8) m_isr[s] = 1'b0;
                  else if (din[7:5] == 3'd3) m_isr[din[2:0]] = 1'b0;
               end else if (din[4:3] == 2'b01 && din[1]) m_rdsel = din[0];
            end
         end
         m_irr = icw1 ? 8'h00 : ((m_irr & ~clr) | rise);
         m_prev_ir  = ir;
         m_prev_stb = stb;
         m_prev_ack = int_ack && stb;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   task automatic tick();
      model_clock();
      @(posedge clock);
      #1;
      if (rand_chk) check("rand int_rq", {7'b0, int_rq}, {7'b0, m_rq});
   endtask

   task automatic wr(input logic wa0, input logic [7:0] d);
      cs = 1; stb = 1; we = 1; a0 = wa0; din = d;
      tick();
      cs = 0; stb = 0; we = 0;
      tick();
   endtask

   task automatic rd_chk(input logic ra0, input logic [7:0] exp, input string nm);
      cs = 1; stb = 1; we = 0; a0 = ra0;
      #1;
      check(nm, dout, exp);
      cs = 0; stb = 0;
   endtask

   task automatic ir_pulse(input logic [7:0] d);
      ir = d;
      tick();
      ir = 0;
   endtask

   task automatic do_ack(input logic [7:0] exp, input int len, input bit use_model, input string nm);
      logic [7:0] e;
      int_ack = 1; stb = 1;
      for (int k = 0; k < len; k++) begin
         tick();
         e = use_model ? m_vec : exp;
         check({nm, " dout"}, dout, e);
      end
      check({nm, " vector"}, vector, e);
      int_ack = 0; stb = 0;
      tick();
   endtask

   // ---------------- directed vector table ----------------
   localparam int OP_WR = 0, OP_RD = 1, OP_IR = 2, OP_RQ = 3, OP_TICK = 4, OP_ACK = 5;
   typedef struct {
      int         op;
      logic       a0;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input int op, input logic va0, input logic [7:0] d, input logic [7:0] e);
      vec_t v;
      v.op = op; v.a0 = va0; v.d = d; v.exp = e;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [7:0] mask;
      cs = 0; stb = 0; we = 0; a0 = 0; din = 0; ir = 0; int_ack = 0; reset_n = 0;
      tick(); tick();
      reset_n = 1;
      check("reset int_rq", {7'b0, int_rq}, 8'h00);
      check("reset vector", vector, 8'h00);
      check("reset dout", dout, 8'h00);
      rd_chk(1, 8'hFF, "reset imr");

      // basic program, ack, nesting
      add(OP_WR, 0, 8'h13, 0); add(OP_WR, 1, 8'h20, 0); add(OP_WR, 1, 8'h01, 0);
      add(OP_WR, 1, 8'hFA, 0); add(OP_RD, 1, 0, 8'hFA);
      add(OP_IR, 0, 8'h01, 0); add(OP_RQ, 0, 0, 8'h00); add(OP_TICK, 0, 0, 0);
      add(OP_RQ, 0, 0, 8'h01); add(OP_ACK, 0, 0, 8'h20); add(OP_RQ, 0, 0, 8'h00);
      add(OP_WR, 0, 8'h0B, 0); add(OP_RD, 0, 0, 8'h01);
      add(OP_IR, 0, 8'h04, 0); add(OP_TICK, 0, 0, 0); add(OP_RQ, 0, 0, 8'h00);
      add(OP_WR, 0, 8'h20, 0); add(OP_RD, 0, 0, 8'h00); add(OP_RQ, 0, 0, 8'h01);
      add(OP_ACK, 0, 0, 8'h22); add(OP_RD, 0, 0, 8'h04); add(OP_WR, 0, 8'h20, 0);
      // simultaneous edges
      add(OP_IR, 0, 8'h05, 0); add(OP_TICK, 0, 0, 0); add(OP_RQ, 0, 0, 8'h01);
      add(OP_ACK, 0, 0, 8'h20); add(OP_WR, 0, 8'h20, 0); add(OP_ACK, 0, 0, 8'h22);
      add(OP_WR, 0, 8'h20, 0); add(OP_WR, 0, 8'h0A, 0); add(OP_RD, 0, 0, 8'h00);
      // masked request stays pending
      add(OP_IR, 0, 8'h02, 0); add(OP_TICK, 0, 0, 0); add(OP_RQ, 0, 0, 8'h00);
      add(OP_RD, 0, 0, 8'h02); add(OP_WR, 1, 8'hF8, 0); add(OP_RQ, 0, 0, 8'h01);
      add(OP_ACK, 0, 0, 8'h21); add(OP_WR, 0, 8'h20, 0); add(OP_RD, 0, 0, 8'h00);
      // automatic EOI
      add(OP_WR, 0, 8'h13, 0); add(OP_WR, 1, 8'h20, 0); add(OP_WR, 1, 8'h03, 0);
      add(OP_WR, 1, 8'hFA, 0); add(OP_IR, 0, 8'h01, 0); add(OP_TICK, 0, 0, 0);
      add(OP_RQ, 0, 0, 8'h01); add(OP_ACK, 0, 0, 8'h20); add(OP_WR, 0, 8'h0B, 0);
      add(OP_RD, 0, 0, 8'h00); add(OP_IR, 0, 8'h01, 0); add(OP_TICK, 0, 0, 0);
      add(OP_RQ, 0, 0, 8'h01); add(OP_ACK, 0, 0, 8'h20); add(OP_RD, 0, 0, 8'h00);
      // spurious acknowledge
      add(OP_ACK, 0, 0, 8'h27); add(OP_RD, 0, 0, 8'h00); add(OP_WR, 0, 8'h0A, 0);
      add(OP_RD, 0, 0, 8'h00);

      for (int i = 0; i < tbl.size(); i++) begin
         case (tbl[i].op)
            OP_WR:   wr(tbl[i].a0, tbl[i].d);
            OP_RD:   rd_chk(tbl[i].a0, tbl[i].exp, $sformatf("tbl[%0d] read", i));
            OP_IR:   ir_pulse(tbl[i].d);
            OP_RQ:   check($sformatf("tbl[%0d] int_rq", i), {7'b0, int_rq}, tbl[i].exp);
            OP_TICK: tick();
            default: do_ack(tbl[i].exp, 1, 0, $sformatf("tbl[%0d] ack", i));
         endcase
      end

      // two-cycle strobe on a non-specific EOI clears only one ISR bit
      wr(0, 8'h13); wr(1, 8'h20); wr(1, 8'h01); wr(1, 8'h00);
      ir_pulse(8'h04); tick();
      do_ack(8'h22, 2, 0, "nest ack ir2");
      ir_pulse(8'h01); tick();
      check("nest int_rq over ir2", {7'b0, int_rq}, 8'h01);
      do_ack(8'h20, 1, 0, "nest ack ir0");
      cs = 1; stb = 1; we = 1; a0 = 0; din = 8'h20;
      tick(); tick();
      cs = 0; stb = 0; we = 0;
      tick();
      wr(0, 8'h0B);
      rd_chk(0, 8'h04, "long strobe isr");

      // held level gives a single request
      wr(0, 8'h20);
      ir = 8'h08; tick(); tick();
      check("level int_rq", {7'b0, int_rq}, 8'h01);
      do_ack(8'h23, 1, 0, "level ack");
      tick(); tick(); tick();
      check("level no retrigger", {7'b0, int_rq}, 8'h00);
      wr(0, 8'h0A);
      rd_chk(0, 8'h00, "level irr");
      ir = 0; tick(); ir = 8'h08; tick(); ir = 0;
      rd_chk(0, 8'h08, "retrigger irr");
      wr(0, 8'h63); wr(0, 8'h0B);
      rd_chk(0, 8'h00, "specific eoi isr");

      // edge arriving with its own acknowledge stays pending
      ir_pulse(8'h01); tick();
      ir = 8'h01;
      do_ack(8'h20, 1, 0, "ack+edge");
      ir = 0;
      check("ack+edge int_rq", {7'b0, int_rq}, 8'h00);
      wr(0, 8'h0A);
      rd_chk(0, 8'h09, "ack+edge irr");

      // reset while awaiting ICW3
      wr(0, 8'h11); wr(1, 8'h20);
      ir_pulse(8'h04);
      check("icw3 int_rq", {7'b0, int_rq}, 8'h00);
      reset_n = 0; tick(); reset_n = 1;
      check("midreset int_rq", {7'b0, int_rq}, 8'h00);
      check("midreset vector", vector, 8'h00);
      rd_chk(0, 8'h00, "midreset irr");
      rd_chk(1, 8'hFF, "midreset imr");
      wr(0, 8'h0B);
      rd_chk(0, 8'h00, "midreset isr");
      wr(1, 8'h55);
      rd_chk(1, 8'h55, "post-reset ocw1");

      // randomized traffic against the model
      for (int round = 0; round < 2; round++) begin
         ir = 0;
         reset_n = 0; tick(); reset_n = 1; tick();
         wr(0, 8'h13);
         wr(1, {5'($urandom_range(0, 31)), 3'b000});
         wr(1, {6'b0, round[0], 1'b1});
         mask = 8'($urandom & $urandom);
         wr(1, mask);
         rand_chk = 1;
         for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: begin
                  if ($urandom_range(0, 1)) ir = 8'($urandom & $urandom);
                  tick();
               end
               4, 5: do_ack(0, $urandom_range(1, 2), 1, "rand ack");
               6: wr(0, $urandom_range(0, 1) ? 8'h20 : {5'b01100, 3'($urandom_range(0, 7))});
               7: wr(1, 8'($urandom & $urandom));
               8: begin
                  wr(0, {6'b000010, 1'b1, 1'($urandom_range(0, 1))});
                  rd_chk(0, m_read(0), "rand read sel");
               end
               default: begin
                  rd_chk(1, m_read(1), "rand imr");
                  rd_chk(0, m_read(0), "rand irr/isr");
               end
            endcase
         end
         rand_chk = 0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/m72_pic.md
Name: m72_pic

Overview:
- Single-device interrupt controller, simplified uPD71059/8259 style.
- Sits directly upstream of the zet CPU interrupt inputs. Replaces the ad-hoc VBLK/HINT trigger logic and the stub INTCS register in the M72 top level.
- Captures rising edges on eight request lines, resolves priority in fully-nested mode, and drives cpu_int_rq.
- Returns the 8-bit vector on the CPU interrupt-acknowledge bus cycle. Programmed through the INTCS I/O window.

Parameters:
- RESET_MASK, 8'hFF, IMR value after reset and after ICW1.
- RESET_BASE, 5'h00, vector base (ICW2[7:3]) after reset.

Ports:
- clock  in  1  system clock; all logic rises on it.
- reset_n  in  1  synchronous, active-low reset.
- cs  in  1  register select (INTCS decode), qualified by stb.
- stb  in  1  CPU bus strobe.
- we  in  1  1 = write.
- a0  in  1  register address (cpu_addr[1]).
- din  in  8  write data (cpu_dout[7:0]).
- dout  out  8  register read data / vector.
- ir  in  8  interrupt request lines, active high, edge-sensitive. IR0 = VBLK, IR2 = HINT.
- int_ack  in  1  CPU acknowledge tag (wb_tgc_o).
- int_rq  out  1  interrupt request to CPU (wb_tgc_i).
- vector  out  8  current acknowledge vector.

Behaviour:
- Reset (reset_n low at a clock edge):
  - IRR=0, ISR=0, IMR=RESET_MASK, base=RESET_BASE.
  - aeoi=0, rd_sel=IRR, init state=READY, ir_d=0, ack_d=0, vector=0.
  - Outputs: int_rq=0, dout=0.
- Register write strobe wr = cs & stb & we & ~int_ack. Acted on only in the first cycle of stb (stb & ~stb_d), so a 2-cycle bus access writes once.
- Init FSM, states READY, W_ICW2, W_ICW3, W_ICW4:
  - a0=0 & din[4]=1 in any state is ICW1:
    - clears IRR, ISR and aeoi; sets IMR=RESET_MASK and rd_sel=IRR.
    - latches sngl=din[1], ic4=din[0]; goes to W_ICW2.
    - An ICW1 mid-sequence restarts the sequence.
  - W_ICW2, a0=1: base<=din[7:3]. Next state is W_ICW3 if sngl=0, else W_ICW4 if ic4=1, else READY.
  - W_ICW3, a0=1: data is ignored (no slaves). Next state is W_ICW4 if ic4=1, else READY.
  - W_ICW4, a0=1: aeoi<=din[1]. Next state READY.
  - In W_* states a write with a0=0 & din[4]=0 is ignored.
- READY-state writes:
  - a0=1: OCW1, IMR<=din.
  - a0=0, din[4:3]=00: OCW2.
    - din[7:5]=001: non-specific EOI, clears highest-priority set ISR bit (lowest index).
    - 011: specific EOI, clears ISR[din[2:0]].
    - Other codes are ignored.
  - a0=0, din[4:3]=01: OCW3. If din[1]=1 then rd_sel<=din[0] (0=IRR, 1=ISR).
- Read data (combinational):
  - dout = vector when int_ack=1.
  - Otherwise a0=1 gives IMR; a0=0 gives IRR or ISR per rd_sel.
- Edge capture:
  - edge = ir & ~ir_d, where ir_d is registered each cycle.
  - IRR_next = (IRR & ~ack_clr) | edge. A new edge in the same cycle as its own acknowledge leaves the bit set.
- Priority:
  - req = IRR & ~IMR. IR0 is highest priority.
  - int_rq = 1 iff init state=READY, req≠0, and lowest-index req bit < lowest-index ISR bit (ISR=0 counts as index 8).
  - int_rq is registered; it changes 1 cycle after its cause.
- Acknowledge, on the first cycle of int_ack & stb (ack_d=0):
  - If a qualifying request exists at level n: vector<=base<<3 | n, ack_clr sets bit n (IRR[n] cleared), ISR[n] set unless aeoi=1.
  - If no request exists (spurious): vector<=base<<3 | 7, IRR and ISR unchanged.
  - vector holds until the next acknowledge. Further cycles of the same strobe do not re-resolve.
- Masking a bit does not clear IRR; unmasking later raises int_rq for that pending edge.
- Level held high produces exactly one request; the line must return low and rise again to retrigger.

Test Plan:
- Program ICW1=0x13, ICW2=0x20, ICW4=0x01, OCW1=0xFA, then pulse ir[0] -> int_rq=1 two cycles later; ack reads vector 0x20; ISR=0x01; int_rq=0.
- With ISR[0] set, pulse ir[2] -> int_rq stays 0. OCW2=0x20 (non-specific EOI) -> ISR=0, int_rq=1; ack gives vector 0x22, ISR=0x04.
- Pulse ir[0] and ir[2] in the same cycle -> first ack gives 0x20; after EOI (0x20) the second ack gives 0x22; IRR=0 at end.
- Pulse ir[1] while IMR[1]=1 -> int_rq=0, IRR=0x02 (OCW3=0x0A then read a0=0). Write OCW1=0xF8 -> int_rq=1, ack gives 0x21.
- ICW4=0x03 (AEOI), pulse ir[0], ack -> vector 0x20 and ISR stays 0x00; immediate ir[0] repulse is acknowledged without EOI.
- Acknowledge with req=0 -> vector 0x27, ISR/IRR unchanged. Assert reset_n=0 mid-sequence (state W_ICW3) -> IMR=0xFF, ISR=IRR=0, int_rq=0; the next ICW2-style write is treated as OCW1.
